// File: rtl/subdiv_sequencer_if.sv
`timescale 1ns/1ps
// subdiv_sequencer_if: start/busy handshakes and shared mesh state between sequencer and stages
interface subdiv_sequencer_if;
   logic        sub_start;
   logic        sub_busy;
   logic        avg_start;
   logic        avg_busy;
   logic        bank_sel;
   logic [31:0] vertex_count;
   logic [31:0] face_count;
   modport master (
      output sub_start, avg_start, bank_sel, vertex_count, face_count,
      input  sub_busy, avg_busy
   );
   modport slave (
      input  sub_start, avg_start, bank_sel, vertex_count, face_count,
      output sub_busy, avg_busy
   );
endinterface

// File: rtl/subdiv_sequencer.sv
`timescale 1ns/1ps
// subdiv_sequencer: iterates subdivide/average stages over ping-pong mesh banks
module subdiv_sequencer #(
   parameter int ADDR_WIDTH         = 11,
   parameter int MAX_NEIGHBOR_COUNT = 10,
   parameter int ACK_TIMEOUT        = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cmd_start,
   input  logic [3:0]         iter_req,
   input  logic [31:0]        vertex_count_in,
   input  logic [31:0]        face_count_in,
   subdiv_sequencer_if.master stg,
   output logic               busy,
   output logic               done,
   output logic               error,
   output logic [1:0]         err_code,
   output logic [3:0]         iter_done
);
   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [63:0] LIMIT = 64'd1 << ADDR_WIDTH;
   typedef enum logic [3:0] {IDLE, CHECK, SUB_REQ, SUB_WAIT, AVG_REQ, AVG_WAIT, SWAP, FINISH, FAULT} state_t;
   state_t        state_q, state_d;
   logic [31:0]   vcnt_q, vcnt_d, fcnt_q, fcnt_d;
   logic [3:0]    req_q, req_d, iter_q, iter_d;
   logic          bank_q, bank_d, err_q, err_d;
   logic [1:0]    code_q, code_d;
   logic [TW-1:0] tmo_q, tmo_d, tmo_inc;
   logic [63:0]   nv, nf;
   logic          too_big, tmo_hit;
   // next-iteration counts, address-space fit and acknowledge-timeout detection
   always_comb begin
      nv = {32'd0, vcnt_q} + ((64'(fcnt_q) * 64'd3) >> 1);
      nf = 64'(fcnt_q) << 2;
      too_big = (64'd1 + 64'd3 * nv + 64'd3 * nf > LIMIT) || (nv * 64'(MAX_NEIGHBOR_COUNT) > LIMIT);
      tmo_hit = tmo_q == TW'(ACK_TIMEOUT - 1);
      tmo_inc = tmo_q == TW'(ACK_TIMEOUT) ? tmo_q : tmo_q + TW'(1);
   end
   // sequencing FSM: next state, counts, bank and error bookkeeping
   always_comb begin
      state_d = state_q;
      vcnt_d  = vcnt_q;
      fcnt_d  = fcnt_q;
      req_d   = req_q;
      iter_d  = iter_q;
      bank_d  = bank_q;
      err_d   = err_q;
      code_d  = code_q;
      tmo_d   = '0;
      case (state_q)
         IDLE: if (cmd_start) begin
            state_d = CHECK;
            vcnt_d  = vertex_count_in;
            fcnt_d  = face_count_in;
            req_d   = iter_req;
            iter_d  = 4'd0;
            bank_d  = 1'b0;
            err_d   = 1'b0;
            code_d  = 2'd0;
         end
         CHECK:
            if (iter_q == req_q) state_d = FINISH;
            else if (fcnt_q[0] || too_big) begin
               state_d = FAULT;
               err_d   = 1'b1;
               code_d  = fcnt_q[0] ? 2'd3 : 2'd1;
            end else state_d = SUB_REQ;
         SUB_REQ:
            if (stg.sub_busy) state_d = SUB_WAIT;
            else if (tmo_hit) begin
               state_d = FAULT;
               err_d   = 1'b1;
               code_d  = 2'd2;
            end else tmo_d = tmo_inc;
         SUB_WAIT: if (!stg.sub_busy) begin
            state_d = AVG_REQ;
            vcnt_d  = nv[31:0];
            fcnt_d  = nf[31:0];
         end
         AVG_REQ:
            if (stg.avg_busy) state_d = AVG_WAIT;
            else if (tmo_hit) begin
               state_d = FAULT;
               err_d   = 1'b1;
               code_d  = 2'd2;
            end else tmo_d = tmo_inc;
         AVG_WAIT: if (!stg.avg_busy) state_d = SWAP;
         SWAP: begin
            state_d = CHECK;
            bank_d  = ~bank_q;
            iter_d  = iter_q + 4'd1;
         end
         default: state_d = IDLE;
      endcase
   end
   // state and datapath registers, cleared by synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         vcnt_q  <= '0;
         fcnt_q  <= '0;
         req_q   <= '0;
         iter_q  <= '0;
         bank_q  <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= '0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         vcnt_q  <= vcnt_d;
         fcnt_q  <= fcnt_d;
         req_q   <= req_d;
         iter_q  <= iter_d;
         bank_q  <= bank_d;
         err_q   <= err_d;
         code_q  <= code_d;
         tmo_q   <= tmo_d;
      end
   end
   assign busy             = !(state_q inside {IDLE, FINISH, FAULT});
   assign done             = state_q == FINISH;
   assign error            = err_q;
   assign err_code         = code_q;
   assign iter_done        = iter_q;
   assign stg.sub_start    = state_q == SUB_REQ;
   assign stg.avg_start    = state_q == AVG_REQ;
   assign stg.bank_sel     = bank_q;
   assign stg.vertex_count = vcnt_q;
   assign stg.face_count   = fcnt_q;
endmodule

// File: tb/tb_subdiv_sequencer.sv
`timescale 1ns/1ps
// tb_subdiv_sequencer: randomized scoreboard bench for subdiv_sequencer
module tb_subdiv_sequencer;
   localparam int AW = 11, MNC = 10, AT = 16;
   typedef struct {int kind; longint v; longint f; int it; int bank; int code;} ev_t;
   logic clk = 0, rst_n = 0, cmd_start = 0;
   logic [3:0] iter_req = 0;
   logic [31:0] vin = 0, fin = 0;
   logic busy, done, error;
   logic [1:0] err_code;
   logic [3:0] iter_done;
   int checks = 0, errors = 0;
   ev_t q[$];
   bit sub_en = 1, avg_en = 1, fixed = 0;
   int sub_rises = 0, avg_rises = 0, avg_len_cur = 0, avg_len_last = 0;

   subdiv_sequencer_if ifc();

   subdiv_sequencer #(.ADDR_WIDTH(AW), .MAX_NEIGHBOR_COUNT(MNC), .ACK_TIMEOUT(AT)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .iter_req(iter_req),
      .vertex_count_in(vin), .face_count_in(fin), .stg(ifc),
      .busy(busy), .done(done), .error(error), .err_code(err_code), .iter_done(iter_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // reference: kind 0 = iteration finished, 1 = done, 2 = fault
   task automatic model(input longint v0, input longint f0, input int it, input bit dead);
      longint v = v0, f = f0, nv, nf;
      int bank = 0;
      for (int i = 0; i < it; i++) begin
         if (f % 2 == 1) begin q.push_back(ev_t'{2, v, f, i, bank, 3}); return; end
         nv = v + 3 * f / 2;
         nf = 4 * f;
         if (1 + 3 * nv + 3 * nf > 2 ** AW || nv * MNC > 2 ** AW) begin
            q.push_back(ev_t'{2, v, f, i, bank, 1});
            return;
         end
         if (dead) begin q.push_back(ev_t'{2, nv, nf, i, bank, 2}); return; end
         v = nv;
         f = nf;
         bank = 1 - bank;
         q.push_back(ev_t'{0, v, f, i + 1, bank, 0});
      end
      q.push_back(ev_t'{1, v, f, it, bank, 0});
   endtask

   task automatic stage(input bit s);
      int lat = fixed ? 0 : $urandom_range(0, 3);
      int dur = fixed ? 5 : $urandom_range(1, 6);
      repeat (lat) @(negedge clk);
      if (s) ifc.sub_busy = 1; else ifc.avg_busy = 1;
      repeat (dur) @(negedge clk);
      if (s) ifc.sub_busy = 0; else ifc.avg_busy = 0;
   endtask

   initial begin
      ifc.sub_busy = 0;
      forever begin
         @(negedge clk);
         if (sub_en && ifc.sub_start) stage(1);
      end
   end

   initial begin
      ifc.avg_busy = 0;
      forever begin
         @(negedge clk);
         if (avg_en && ifc.avg_start) stage(0);
      end
   end

   task automatic handle(input int kind);
      ev_t e;
      if (q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_event: got kind %0d expected none", kind);
         return;
      end
      e = q.pop_front();
      chk("ev_kind", kind, e.kind);
      chk("ev_vertex_count", ifc.vertex_count, e.v);
      chk("ev_face_count", ifc.face_count, e.f);
      chk("ev_iter_done", iter_done, e.it);
      chk("ev_bank_sel", ifc.bank_sel, e.bank);
      if (kind != 0) chk("ev_busy", busy, 0);
      if (kind == 2) chk("ev_err_code", err_code, e.code);
      if (kind == 1) chk("ev_error", error, 0);
   endtask

   // monitor: pops the scoreboard whenever the DUT reports progress, done or fault
   initial begin
      logic p_err = 0, p_sub = 0, p_avg = 0;
      logic [3:0] p_it = 0;
      forever begin
         @(negedge clk);
         chk("strobe_exclusive", ifc.sub_start && ifc.avg_start, 0);
         if (ifc.sub_start && !p_sub) sub_rises++;
         if (ifc.avg_start && !p_avg) avg_rises++;
         if (ifc.avg_start) avg_len_cur++;
         else if (avg_len_cur > 0) begin
            avg_len_last = avg_len_cur;
            avg_len_cur = 0;
         end
         if (done) handle(1);
         if (error && !p_err) handle(2);
         if (iter_done != p_it && iter_done != 0) handle(0);
         p_err = error;
         p_sub = ifc.sub_start;
         p_avg = ifc.avg_start;
         p_it = iter_done;
      end
   end

   task automatic start(input longint v, input longint f, input int it, input bit dead);
      model(v, f, it, dead);
      @(negedge clk);
      vin = 32'(v);
      fin = 32'(f);
      iter_req = 4'(it);
      cmd_start = 1;
      @(negedge clk);
      cmd_start = 0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_terminates"}, busy, 0);
      @(negedge clk);
      chk({name, "_queue_drained"}, q.size(), 0);
   endtask

   task automatic zeros(input string name);
      chk({name, "_flags"}, {busy, done, error, err_code, iter_done, ifc.sub_start, ifc.avg_start, ifc.bank_sel}, 0);
      chk({name, "_vertex_count"}, ifc.vertex_count, 0);
      chk({name, "_face_count"}, ifc.face_count, 0);
   endtask

   task automatic zero_run(input longint v, input longint f);
      start(v, f, 0, 0);
      chk("zero_busy_c1", busy, 1);
      chk("zero_done_c1", done, 0);
      @(negedge clk);
      chk("zero_done_c2", done, 1);
      chk("zero_vertex_count", ifc.vertex_count, v);
      chk("zero_face_count", ifc.face_count, f);
      wait_idle("zero");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int s0, a0, n;
      repeat (3) @(negedge clk);
      zeros("reset");
      rst_n = 1;
      fixed = 1;
      s0 = sub_rises;
      start(4, 4, 2, 0);
      wait_idle("basic");
      chk("basic_vertex_count", ifc.vertex_count, 34);
      chk("basic_face_count", ifc.face_count, 64);
      chk("basic_iter_done", iter_done, 2);
      chk("basic_bank_sel", ifc.bank_sel, 0);
      chk("basic_error", error, 0);
      chk("basic_sub_strobes", sub_rises - s0, 2);
      fixed = 0;
      s0 = sub_rises;
      start(4, 4, 5, 0);
      wait_idle("overflow");
      chk("overflow_error", error, 1);
      chk("overflow_err_code", err_code, 1);
      chk("overflow_iter_done", iter_done, 3);
      chk("overflow_sub_strobes", sub_rises - s0, 3);
      avg_en = 0;
      start(4, 4, 1, 1);
      wait_idle("timeout");
      chk("timeout_avg_start_len", avg_len_last, AT);
      chk("timeout_error", error, 1);
      chk("timeout_err_code", err_code, 2);
      avg_en = 1;
      s0 = sub_rises;
      a0 = avg_rises;
      start(4, 3, 1, 0);
      chk("odd_error_cleared", error, 0);
      @(negedge clk);
      chk("odd_error", error, 1);
      chk("odd_err_code", err_code, 3);
      wait_idle("odd");
      chk("odd_strobes", (sub_rises - s0) + (avg_rises - a0), 0);
      fixed = 1;
      start(4, 4, 2, 0);
      n = 0;
      while (!ifc.sub_busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("midrst_sub_ack", ifc.sub_busy, 1);
      @(negedge clk);
      q.delete();
      rst_n = 0;
      @(negedge clk);
      zeros("midrst");
      rst_n = 1;
      repeat (12) @(negedge clk);
      zero_run(9, 6);
      fixed = 0;
      start(4, 4, 2, 0);
      repeat (3) @(negedge clk);
      vin = 7;
      fin = 2;
      iter_req = 1;
      cmd_start = 1;
      @(negedge clk);
      cmd_start = 0;
      n = 0;
      while (!done && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("ignore_done_seen", done, 1);
      vin = 99;
      fin = 8;
      iter_req = 0;
      cmd_start = 1;
      @(negedge clk);
      cmd_start = 0;
      chk("ignore_busy", busy, 0);
      chk("ignore_vertex_count", ifc.vertex_count, 34);
      chk("ignore_face_count", ifc.face_count, 64);
      chk("ignore_iter_done", iter_done, 2);
      repeat (3) @(negedge clk);
      chk("ignore_queue_drained", q.size(), 0);
      for (int r = 0; r < 25; r++) begin
         longint v = $urandom_range(0, 60);
         longint f = 2 * $urandom_range(0, 20) + ($urandom_range(0, 4) == 0 ? 1 : 0);
         int it = $urandom_range(0, 5);
         bit dead = $urandom_range(0, 7) == 0;
         fixed = $urandom_range(0, 1) == 1;
         avg_en = !dead;
         start(v, f, it, dead);
         wait_idle("rand");
      end
      avg_en = 1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
